div8u4_seq: RTL and testbench
=============================

DIV8U4_SEQ -- requirements
Module: div8u4_seq

Interface
REQ-001 Parameter CHECK_EN, default 1, enables a one-cycle multiply-back self-check stage (1 = present, 0 = bypassed).
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  dividend/divisor offered.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 dividend  input  8  unsigned dividend A[7:0].
REQ-008 divisor  input  4  unsigned divisor B[3:0].
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 quotient  output  8  unsigned Q[7:0].
REQ-012 remainder  output  4  unsigned R[3:0].
REQ-013 dbz  output  1  divide-by-zero flag for the current result.
REQ-014 err  output  1  self-check mismatch flag for the current result; constant 0 when CHECK_EN=0.

Function
REQ-015 The FSM SHALL have the states IDLE, CALC, CHECK and DONE; CHECK exists only when CHECK_EN=1.
REQ-016 in_ready SHALL be 1 only in IDLE, so no new operands are accepted while busy.
REQ-017 On the edge with in_valid&in_ready, the block SHALL capture dividend and divisor, clear the partial remainder and the iteration counter, and move IDLE->CALC (or IDLE->DONE if divisor=0).
REQ-018 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first: Rp = {R[3:0], next dividend bit} (5 bits); if Rp >= B then R = Rp-B and the quotient bit = 1, else R = Rp and the quotient bit = 0.
REQ-019 CALC SHALL last exactly 8 cycles, counted by a 3-bit counter; it leaves CALC on the edge where the counter wraps from 7.
REQ-020 Exit from CALC SHALL go to CHECK when CHECK_EN=1, else to DONE.
REQ-021 CHECK SHALL compute Q*B+R in 12 bits, set err=1 if the result differs from the captured dividend, then move to DONE after 1 cycle.
REQ-022 Latency from the accept edge to out_valid=1 SHALL be 9 cycles with CHECK_EN=1 and 8 cycles with CHECK_EN=0, for any nonzero divisor.
REQ-023 Divisor=0 SHALL skip CALC and CHECK and produce, 1 cycle after accept: quotient=8'hFF, remainder=4'hF, dbz=1, err=0.
REQ-024 out_valid SHALL be 1 only in DONE; quotient, remainder, dbz and err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 On the edge with out_valid&out_ready, the FSM SHALL go DONE->IDLE and drop out_valid; in_ready rises in the same cycle, so a new accept is possible on the following edge.
REQ-026 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-027 For nonzero B, results SHALL satisfy Q = floor(A/B), R = A mod B, R < B and dbz=0; a fault-free datapath gives err=0.
REQ-028 Outputs quotient, remainder, dbz and err SHALL come directly from registers, with no combinational path from any input.

Reset
REQ-029 Asserting rst SHALL immediately force state=IDLE, in_ready=1 (visible while rst is high), out_valid=0, quotient=0, remainder=0, dbz=0, err=0, and clear the counter.
REQ-030 Reset asserted during CALC, CHECK or DONE SHALL abandon the operation; no result is presented after reset is released.
REQ-031 The first accept SHALL be possible on the first rising edge after rst is deasserted.

Verification
REQ-032 Accept A=200, B=7 with CHECK_EN=1 -> out_valid rises exactly 9 cycles later with Q=28, R=4, dbz=0, err=0.
REQ-033 Accept A=255, B=1 -> Q=255, R=0; accept A=5, B=9 -> Q=0, R=5; with CHECK_EN=0 the latency is 8 cycles.
REQ-034 Accept A=100, B=0 -> 1 cycle later out_valid=1, Q=8'hFF, R=4'hF, dbz=1, err=0.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operands -> outputs unchanged, in_ready=0; then out_ready=1 -> IDLE on the next edge.
REQ-036 Assert rst at CALC iteration 4 -> out_valid=0 and in_ready=1 immediately; after release, A=13, B=3 -> Q=4, R=1.
REQ-037 Run all 4096 (A,B) pairs back-to-back with random out_ready stalls -> every result matches a reference model, and err never asserts.

Source files
------------

// File: rtl/div8u4_seq.sv
// Sequential 8-bit by 4-bit unsigned restoring divider with a valid/ready handshake
// and an optional multiply-back self-check cycle before the result is presented.
module div8u4_seq #(
    parameter int unsigned CHECK_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       dbz,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StCalc, StCheck, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  a_q;
    logic [3:0]  b_q;
    logic [2:0]  cnt_q;
    logic        err_q;

    logic [4:0]  rp;
    logic [3:0]  rdiff;
    logic        qbit;
    logic [11:0] recon;

    // quotient/remainder double as the working registers during CALC
    always_comb begin
        rp    = {remainder, a_q[3'd7 - cnt_q]};
        qbit  = (rp >= {1'b0, b_q});
        // rp - b < b whenever qbit is set, so the low nibble is the exact difference
        rdiff = rp[3:0] - b_q;
        recon = ({4'b0, quotient} * {8'b0, b_q}) + {8'b0, remainder};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = (divisor == 4'd0) ? StDone : StCalc;
            StCalc:  if (cnt_q == 3'd7) state_d = (CHECK_EN != 0) ? StCheck : StDone;
            StCheck: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= 8'd0;
            b_q       <= 4'd0;
            cnt_q     <= 3'd0;
            err_q     <= 1'b0;
            quotient  <= 8'd0;
            remainder <= 4'd0;
            dbz       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= dividend;
                        b_q   <= divisor;
                        cnt_q <= 3'd0;
                        err_q <= 1'b0;
                        if (divisor == 4'd0) begin
                            quotient  <= 8'hFF;
                            remainder <= 4'hF;
                            dbz       <= 1'b1;
                        end else begin
                            quotient  <= 8'd0;
                            remainder <= 4'd0;
                            dbz       <= 1'b0;
                        end
                    end
                end
                StCalc: begin
                    cnt_q     <= cnt_q + 3'd1;
                    quotient  <= {quotient[6:0], qbit};
                    remainder <= qbit ? rdiff : rp[3:0];
                end
                StCheck: begin
                    err_q <= (recon != {4'b0, a_q});
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign err       = (CHECK_EN != 0) ? err_q : 1'b0;

endmodule

// File: tb/tb_div8u4_seq.sv
// Randomized self-checking bench for div8u4_seq: one instance with the self-check stage,
// one without, both compared against a plain-arithmetic division model.
module tb_div8u4_seq;

    logic       clk;
    logic       rst;
    logic       in_valid1, in_valid0;
    logic       out_ready1, out_ready0;
    logic [7:0] dividend;
    logic [3:0] divisor;

    logic       in_ready1, out_valid1, dbz1, err1;
    logic [7:0] quotient1;
    logic [3:0] remainder1;
    logic       in_ready0, out_valid0, dbz0, err0;
    logic [7:0] quotient0;
    logic [3:0] remainder0;

    int n_checks;
    int n_errors;
    int cur;

    logic       s_rdy, s_ov, s_dbz, s_err;
    logic [7:0] s_q;
    logic [3:0] s_r;

    div8u4_seq #(.CHECK_EN(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid1),
        .out_ready(out_ready1),
        .quotient (quotient1),
        .remainder(remainder1),
        .dbz      (dbz1),
        .err      (err1)
    );

    div8u4_seq #(.CHECK_EN(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid0),
        .in_ready (in_ready0),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid0),
        .out_ready(out_ready0),
        .quotient (quotient0),
        .remainder(remainder0),
        .dbz      (dbz0),
        .err      (err0)
    );

    assign s_rdy = (cur != 0) ? in_ready1  : in_ready0;
    assign s_ov  = (cur != 0) ? out_valid1 : out_valid0;
    assign s_dbz = (cur != 0) ? dbz1       : dbz0;
    assign s_err = (cur != 0) ? err1       : err0;
    assign s_q   = (cur != 0) ? quotient1  : quotient0;
    assign s_r   = (cur != 0) ? remainder1 : remainder0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic ref_div(input logic [7:0] a, input logic [3:0] b,
                           output logic [7:0] q, output logic [3:0] r, output logic z);
        if (b == 4'd0) begin
            q = 8'hFF;
            r = 4'hF;
            z = 1'b1;
        end else begin
            q = 8'(int'(a) / int'(b));
            r = 4'(int'(a) % int'(b));
            z = 1'b0;
        end
    endtask

    task automatic set_iv(input logic v);
        if (cur != 0) in_valid1 = v;
        else          in_valid0 = v;
    endtask

    task automatic set_or(input logic v);
        if (cur != 0) out_ready1 = v;
        else          out_ready0 = v;
    endtask

    // One full transaction; during the stall the inputs are scrambled and must be ignored.
    task automatic run_op(input int sel, input logic [7:0] a, input logic [3:0] b,
                          input int stall);
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        int         lat;
        int         exp_lat;
        cur = sel;
        ref_div(a, b, eq, er, ez);
        exp_lat = (b == 4'd0) ? 0 : ((sel != 0) ? 9 : 8);
        #0;
        check("ready_before_accept", s_rdy, 1);
        dividend = a;
        divisor  = b;
        set_iv(1'b1);
        @(posedge clk);
        #1;
        set_iv(1'b0);
        lat = 0;
        while (!s_ov && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("quotient", s_q, eq);
        check("remainder", s_r, er);
        check("dbz", s_dbz, ez);
        check("err", s_err, 0);
        for (int i = 0; i < stall; i++) begin
            set_iv(i[0] == 1'b0);
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
            @(posedge clk);
            #1;
            check("hold_result", {s_ov, s_rdy, s_dbz, s_err, s_q, s_r}, {1'b1, 1'b0, ez, 1'b0, eq, er});
        end
        set_iv(1'b0);
        set_or(1'b1);
        @(posedge clk);
        #1;
        set_or(1'b0);
        check("released_valid", s_ov, 0);
        check("released_ready", s_rdy, 1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cur        = 1;
        rst        = 1'b1;
        in_valid1  = 1'b0;
        in_valid0  = 1'b0;
        out_ready1 = 1'b0;
        out_ready0 = 1'b0;
        dividend   = 8'd0;
        divisor    = 4'd0;
        #1;
        check("rst_ready", in_ready1, 1);
        check("rst_valid", out_valid1, 0);
        check("rst_outs", {quotient1, remainder1, dbz1, err1}, 0);
        check("rst_ready0", in_ready0, 1);
        check("rst_outs0", {out_valid0, quotient0, remainder0, dbz0, err0}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_op(1, 8'd200, 4'd7, 0);
        run_op(1, 8'd255, 4'd1, 1);
        run_op(0, 8'd255, 4'd1, 0);
        run_op(0, 8'd5, 4'd9, 2);
        run_op(1, 8'd100, 4'd0, 0);
        run_op(0, 8'd100, 4'd0, 1);
        run_op(1, 8'd77, 4'd6, 5);

        // Reset in the middle of CALC abandons the operation.
        cur       = 1;
        dividend  = 8'd99;
        divisor   = 4'd5;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_ready", in_ready1, 0);
        rst = 1'b1;
        #1;
        check("midrst_ready", in_ready1, 1);
        check("midrst_valid", out_valid1, 0);
        check("midrst_outs", {quotient1, remainder1, dbz1, err1}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_valid", out_valid1, 0);
        run_op(1, 8'd13, 4'd3, 0);

        for (int i = 0; i < 200; i++) begin
            run_op(0, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)));
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(1, 8'(a), 4'(b), int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
